// File: rtl/dbus_responder_pkg.sv
// Shared types for the dbus responder: request/response bundles,
// FSM state encoding and the byte-strobe merge helper.
package dbus_responder_pkg;

    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        MSIZE1,
        MSIZE2,
        MSIZE4,
        MSIZE8
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dbus_rsp_state_t;

    function automatic u64 strobe_merge(u64 old_w, u64 new_w, logic [7:0] strobe);
        u64 r;
        r = old_w;
        for (int i = 0; i < 8; i++) begin
            if (strobe[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Data-bus request/response pair between the memory stage and a responder.
interface dbus_responder_if;
    import dbus_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_responder_sram.sv
// Single-port 64-bit SRAM with byte enables and registered read data.
module dbus_sram
    import dbus_responder_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [7:0]    i_be,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [2**AW];
    logic [63:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= strobe_merge(r_mem[i_addr], i_wdata, i_be);
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: request FSM with programmable latency, window check,
// sticky out-of-window flag, backed by a byte-strobed SRAM.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int          AW        = 12,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic             clk,
    input  logic             resetn,
    dbus_responder_if.slave  dbus,
    output logic             busy,
    output logic             oob
);

    localparam logic [63:0] WIN    = 64'd8 << AW;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    dbus_rsp_state_t r_state, w_next;
    logic [3:0]      r_cnt, w_cnt;
    logic [AW-1:0]   r_idx;
    logic [7:0]      r_strb;
    logic [63:0]     r_wdata;
    logic            r_inwin;
    logic            r_oob;

    logic [63:0]     w_diff;
    logic            w_inwin;
    logic [AW-1:0]   w_idx;
    logic            w_accept;
    logic [AW-1:0]   w_sram_addr;
    logic            w_we;
    logic [63:0]     w_rdata;
    dbus_resp_t      w_resp;
    logic            w_unused;

    // Unsigned 64-bit difference also catches addresses below the base.
    assign w_diff   = dbus.dreq.addr - BASE_ADDR;
    assign w_inwin  = w_diff < WIN;
    assign w_idx    = w_diff[AW+2:3];
    assign w_accept = (r_state == IDLE) && dbus.dreq.valid;
    assign w_unused = ^{w_diff[63:AW+3], w_diff[2:0], dbus.dreq.size};

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (dbus.dreq.valid) begin
                    w_cnt  = LAT_M1;
                    w_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!dbus.dreq.valid) begin
                    w_next = IDLE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_oob   <= 1'b0;
            r_idx   <= '0;
            r_strb  <= '0;
            r_wdata <= '0;
            r_inwin <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_strb  <= dbus.dreq.strobe;
                r_wdata <= dbus.dreq.data;
                r_inwin <= w_inwin;
                if (!w_inwin) r_oob <= 1'b1;
            end
        end
    end

    // In IDLE the SRAM looks at the live address so LATENCY=1 reads land on time.
    assign w_sram_addr = (r_state == IDLE) ? w_idx : r_idx;
    assign w_we        = (r_state == RESP) && (r_strb != 8'h00) && r_inwin;

    dbus_sram #(.AW(AW)) u_sram (
        .clk     (clk),
        .i_addr  (w_sram_addr),
        .i_we    (w_we),
        .i_be    (r_strb),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_resp         = '0;
        w_resp.addr_ok = resetn && w_accept;
        w_resp.data_ok = (r_state == RESP);
        if ((r_state == RESP) && (r_strb == 8'h00) && r_inwin) begin
            w_resp.data = w_rdata;
        end
    end

    assign dbus.dresp = w_resp;
    assign busy       = (r_state != IDLE);
    assign oob        = r_oob;

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboard bench for dbus_responder across LATENCY 1, 2, 3 and 15.
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    localparam int          AW   = 12;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          LATS [4] = '{1, 2, 3, 15};

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          cyc = 0;
    int          errs = 0;
    int          checks = 0;
    dbus_req_t   req [4];
    dbus_resp_t  rsp [4];
    logic        busy [4];
    logic        oob [4];
    int          npulse [4] = '{0, 0, 0, 0};
    exp_t        q [4][$];
    logic [63:0] vals [3] = '{64'h0101_0101_0101_0101,
                              64'h2222_3333_4444_5555,
                              64'hCAFE_F00D_1234_5678};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 4; g++) begin : gd
        dbus_responder_if ifc ();
        assign ifc.dreq = req[g];
        assign rsp[g]   = ifc.dresp;
        dbus_responder #(
            .AW        (AW),
            .LATENCY   (LATS[g]),
            .BASE_ADDR (BASE)
        ) dut (
            .clk    (clk),
            .resetn (resetn),
            .dbus   (ifc),
            .busy   (busy[g]),
            .oob    (oob[g])
        );
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (resetn && rsp[g].data_ok) begin
                exp_t e;
                npulse[g]++;
                chk("dok_expected", 64'(q[g].size() != 0), 64'd1);
                if (q[g].size() != 0) begin
                    e = q[g].pop_front();
                    chk("dok_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rdata", rsp[g].data, e.data);
                end
            end
        end
    end

    task automatic drive(int g, logic [63:0] a, logic [7:0] s, logic [63:0] d);
        req[g].valid  = 1'b1;
        req[g].addr   = a;
        req[g].size   = MSIZE8;
        req[g].strobe = s;
        req[g].data   = d;
    endtask

    task automatic accept(int g, logic [63:0] a, logic [7:0] s, logic [63:0] d);
        @(posedge clk);
        #1;
        drive(g, a, s, d);
        @(negedge clk);
        chk("addr_ok", 64'(rsp[g].addr_ok), 64'd1);
    endtask

    task automatic access(int g, logic [63:0] a, logic [7:0] s,
                          logic [63:0] d, logic [63:0] e);
        exp_t x;
        int   n;
        accept(g, a, s, d);
        x.data = e;
        x.cyc  = cyc + LATS[g];
        q[g].push_back(x);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp[g].data_ok && n < 40);
        chk("dok_seen", 64'(rsp[g].data_ok), 64'd1);
        @(posedge clk);
        #1;
        req[g].valid = 1'b0;
    endtask

    task automatic rst_mid(int g, int extra, logic [63:0] a, logic [63:0] old);
        accept(g, a, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
        repeat (extra + 1) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy[g]), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst_aok", 64'(rsp[g].addr_ok), 64'd0);
        chk("rst_dok", 64'(rsp[g].data_ok), 64'd0);
        chk("rst_data", rsp[g].data, 64'd0);
        chk("rst_busy", 64'(busy[g]), 64'd0);
        req[g].valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy[g]), 64'd0);
        access(g, a, 8'h00, 64'd0, old);
    endtask

    initial begin
        for (int g = 0; g < 4; g++) begin
            req[g] = '0;
            req[g].valid = 1'b1;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("reset_ctl", 64'({rsp[g].addr_ok, rsp[g].data_ok, busy[g], oob[g]}), 64'd0);
            chk("reset_data", rsp[g].data, 64'd0);
            req[g].valid = 1'b0;
        end
        resetn = 1'b1;

        for (int g = 0; g < 4; g++) begin
            access(g, BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, 64'd0);
            access(g, BASE + 64'h10, 8'h00, 64'd0, 64'h1122_3344_5566_7788);
        end

        access(1, BASE + 64'h10, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0);
        access(1, BASE + 64'h10, 8'h00, 64'd0, 64'h1122_3344_CCCC_DDDD);
        access(1, BASE + 64'h13, 8'h00, 64'd0, 64'h1122_3344_CCCC_DDDD);
        access(1, BASE + 64'h18, 8'hA5, 64'h8877_6655_4433_2211, 64'd0);
        access(1, BASE + 64'h18, 8'h5A, 64'hFFEE_DDCC_BBAA_9988, 64'd0);
        access(1, BASE + 64'h18, 8'h00, 64'd0, 64'h88EE_66CC_BB33_9911);

        access(1, BASE, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0);
        access(1, BASE + 64'h7FF8, 8'hFF, 64'hFEDC_BA98_7654_3210, 64'd0);
        chk("oob_clear", 64'(oob[1]), 64'd0);
        access(1, 64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        chk("oob_low", 64'(oob[1]), 64'd1);
        access(1, 64'h7FFF_FFF8, 8'h00, 64'd0, 64'd0);
        access(1, BASE + 64'h8000, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, 64'd0);
        access(1, BASE + 64'h8000, 8'h00, 64'd0, 64'd0);
        access(1, BASE, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF);
        access(1, BASE + 64'h7FF8, 8'h00, 64'd0, 64'hFEDC_BA98_7654_3210);
        chk("oob_sticky", 64'(oob[1]), 64'd1);
        chk("oob_other", 64'(oob[0]), 64'd0);
        access(2, BASE + 64'h8000, 8'h00, 64'd0, 64'd0);
        chk("oob_high", 64'(oob[2]), 64'd1);

        access(2, BASE + 64'h40, 8'hFF, 64'h5555_6666_7777_8888, 64'd0);
        accept(2, BASE + 64'h40, 8'hFF, 64'h9999_9999_9999_9999);
        @(posedge clk);
        #1;
        req[2].valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", 64'(busy[2]), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("abort_dok", 64'(rsp[2].data_ok), 64'd0);
            @(negedge clk);
        end
        access(2, BASE + 64'h40, 8'h00, 64'd0, 64'h5555_6666_7777_8888);

        for (int k = 0; k < 3; k++) begin
            access(0, BASE + 64'h100 + 64'(8 * k), 8'hFF, vals[k], 64'd0);
        end
        begin
            int   p0;
            exp_t x;
            p0 = npulse[0];
            @(posedge clk);
            #1;
            drive(0, BASE + 64'h100, 8'h00, 64'd0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("b2b_aok", 64'(rsp[0].addr_ok), 64'd1);
                x.data = vals[k];
                x.cyc  = cyc + 1;
                q[0].push_back(x);
                @(negedge clk);
                @(posedge clk);
                #1;
                if (k < 2) req[0].addr = BASE + 64'h100 + 64'(8 * (k + 1));
                else req[0].valid = 1'b0;
            end
            repeat (3) @(negedge clk);
            chk("b2b_pulses", 64'(npulse[0] - p0), 64'd3);
        end

        rst_mid(1, 0, BASE + 64'h10, 64'h1122_3344_CCCC_DDDD);
        chk("oob_after_rst", 64'(oob[1]), 64'd0);
        rst_mid(0, 0, BASE + 64'h100, vals[0]);
        access(3, BASE + 64'h200, 8'hFF, 64'h0F0F_0F0F_F0F0_F0F0, 64'd0);
        rst_mid(3, 5, BASE + 64'h200, 64'h0F0F_0F0F_F0F0_F0F0);

        for (int g = 0; g < 4; g++) begin
            chk("sb_drained", 64'(q[g].size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
